// File: rtl/aes_encrypt_iter_if.sv
// aes_encrypt_iter_if: block-in/block-out bus of aes_encrypt_iter; outReady exists only with AES_BACKPRESSURE_EN
interface aes_encrypt_iter_if #(parameter int KW = 1408);
  logic [127:0] data;
  logic [KW-1:0] allKeys;
  logic inValid;
  logic inReady;
  logic [127:0] out;
  logic outValid;
  logic busy;
`ifdef AES_BACKPRESSURE_EN
  logic outReady;
  modport master (output data, allKeys, inValid, outReady, input inReady, out, outValid, busy);
  modport slave (input data, allKeys, inValid, outReady, output inReady, out, outValid, busy);
`else
  modport master (output data, allKeys, inValid, input inReady, out, outValid, busy);
  modport slave (input data, allKeys, inValid, output inReady, out, outValid, busy);
`endif
endinterface

// File: rtl/aes_encrypt_iter.sv
// aes_encrypt_iter: iterative AES-128/192/256 encryptor, one round per clock; AES_BACKPRESSURE_EN holds DONE until outReady
module aes_encrypt_iter #(
  parameter int Nk = 4,
  localparam int Nr = Nk + 6,
  localparam int KW = 128 * (Nr + 1)
) (
  input logic clk,
  input logic reset,
  aes_encrypt_iter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ROUND, LAST, DONE} fsm_t;
  fsm_t fsm, fsm_n;
  logic [3:0] round;
  logic [127:0] state, ss;
  logic [KW-1:0] keys;
  logic [127:0] rk [Nr+1];
  logic done_exit;

  if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
    $error("aes_encrypt_iter: Nk must be 4, 6 or 8");
  end

  assign keys = bus.allKeys;
  for (genvar i = 0; i <= Nr; i++) begin : g_rk
    assign rk[i] = keys[128*i +: 128];
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = xt(x);
    end
    return p;
  endfunction

  // inverse as x^254 in GF(2^8), then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, y;
    x2 = gm(x, x);
    x3 = gm(x2, x);
    x12 = gm(gm(x3, x3), gm(x3, x3));
    x15 = gm(x12, x3);
    x240 = gm(x15, x15);
    x240 = gm(x240, x240);
    x240 = gm(x240, x240);
    x240 = gm(x240, x240);
    y = gm(gm(x240, x12), x2);
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o;
  endfunction

`ifdef AES_BACKPRESSURE_EN
  assign done_exit = bus.outReady;
`else
  assign done_exit = 1'b1;
`endif

  assign ss = sub_shift(state);

  always_comb begin
    fsm_n = fsm == IDLE ? (bus.inValid ? ROUND : IDLE) :
            fsm == ROUND ? (round == 4'(Nr - 1) ? LAST : ROUND) :
            fsm == LAST ? DONE : (done_exit ? IDLE : DONE);
    bus.inReady = fsm == IDLE;
    bus.busy = fsm == ROUND || fsm == LAST;
    bus.outValid = fsm == DONE;
    bus.out = state;
  end

  always_ff @(posedge clk)
    if (reset) begin
      fsm <= IDLE;
      round <= '0;
      state <= '0;
    end else begin
      fsm <= fsm_n;
      if (fsm == IDLE && bus.inValid) begin
        state <= bus.data ^ rk[0];
        round <= 4'd1;
      end else if (fsm == ROUND) begin
        state <= mix(ss) ^ rk[round];
        round <= round + 4'd1;
      end else if (fsm == LAST)
        state <= ss ^ rk[Nr];
    end
endmodule

// File: tb/tb_aes_encrypt_iter.sv
// tb_aes_encrypt_iter: checks aes_encrypt_iter for Nk=4/6/8 against known vectors and a byte-level AES reference
module tb_aes_encrypt_iter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  aes_encrypt_iter_if #(.KW(1408)) b4 ();
  aes_encrypt_iter_if #(.KW(1664)) b6 ();
  aes_encrypt_iter_if #(.KW(1920)) b8 ();
  aes_encrypt_iter #(.Nk(4)) d4 (.clk(clk), .reset(reset), .bus(b4));
  aes_encrypt_iter #(.Nk(6)) d6 (.clk(clk), .reset(reset), .bus(b6));
  aes_encrypt_iter #(.Nk(8)) d8 (.clk(clk), .reset(reset), .bus(b8));

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] sb [256];

  localparam logic [255:0] K4 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K6 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C8 = 128'h8ea2b7ca516745bfeafc49904b496089;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] tx(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // walks generator 3 and its inverse generator together to fill the S-box
  task automatic init_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  function automatic logic [1919:0] expand(input int nk, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    logic [1919:0] res;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    res = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = tx(rc);
      end else if (nk > 6 && i % nk == 4) t = sub_word(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) res[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return res;
  endfunction

  function automatic logic [127:0] aes_ref(input int nk, input logic [255:0] key, input logic [127:0] pt);
    logic [1919:0] ks;
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] v;
    int nr;
    nr = nk + 6;
    ks = expand(nk, key);
    v = pt ^ ks[127:0];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[v[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[w+4*c] = s[w+4*((c+w)%4)];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          s[w+4*c] = r == nr ? t[w+4*c] :
                     tx(t[4*c+w]) ^ tx(t[4*c+(w+1)%4]) ^ t[4*c+(w+1)%4] ^ t[4*c+(w+2)%4] ^ t[4*c+(w+3)%4];
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
      v = v ^ ks[128*r +: 128];
    end
    return v;
  endfunction

  task automatic drive(input int nk, input logic v, input logic [127:0] d, input logic [1919:0] k);
    case (nk)
      4: begin b4.inValid = v; b4.data = d; b4.allKeys = k[1407:0]; end
      6: begin b6.inValid = v; b6.data = d; b6.allKeys = k[1663:0]; end
      default: begin b8.inValid = v; b8.data = d; b8.allKeys = k; end
    endcase
  endtask

  function automatic logic ov(input int nk);
    return nk == 4 ? b4.outValid : nk == 6 ? b6.outValid : b8.outValid;
  endfunction
  function automatic logic rdy(input int nk);
    return nk == 4 ? b4.inReady : nk == 6 ? b6.inReady : b8.inReady;
  endfunction
  function automatic logic bsy(input int nk);
    return nk == 4 ? b4.busy : nk == 6 ? b6.busy : b8.busy;
  endfunction
  function automatic logic [127:0] outv(input int nk);
    return nk == 4 ? b4.out : nk == 6 ? b6.out : b8.out;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_block(input int nk, input logic [255:0] key, input logic [127:0] pt,
                           input logic [127:0] exp, input string tag);
    logic [1919:0] ks;
    int k;
    ks = expand(nk, key);
    @(negedge clk);
    chk({tag, "_ready"}, 128'(rdy(nk)), 128'd1);
    drive(nk, 1'b1, pt, ks);
    @(negedge clk);
    drive(nk, 1'b0, rnd128(), ks);
    chk({tag, "_busy"}, 128'({bsy(nk), rdy(nk)}), 128'b10);
    k = 0;
    while (!ov(nk) && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, 128'(k), 128'(nk + 6));
    chk({tag, "_out"}, outv(nk), exp);
    @(negedge clk);
    chk({tag, "_pulse"}, 128'({ov(nk), rdy(nk)}), 128'b01);
  endtask

  initial begin
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] pts [3];
    logic [127:0] outs [$];
    logic [1919:0] ks;
    int acc [$];
    int oc [$];
    int idx, pulses, bad, k;
    init_sbox();
    drive(4, 1'b0, '0, '0);
    drive(6, 1'b0, '0, '0);
    drive(8, 1'b0, '0, '0);
`ifdef AES_BACKPRESSURE_EN
    b4.outReady = 1'b1;
    b6.outReady = 1'b1;
    b8.outReady = 1'b1;
`endif
    repeat (2) @(negedge clk);
    chk("reset_flags", 128'({b4.outValid, b4.busy, b4.inReady}), 128'b001);
    chk("reset_state", b4.out, 128'h0);
    reset = 1'b0;

    run_block(4, K4, PT, C4, "vec128");
    run_block(6, K6, PT, C6, "vec192");
    run_block(8, K8, PT, C8, "vec256");
    for (int i = 0; i < 3; i++) begin
      key = {rnd128(), rnd128()};
      pt = rnd128();
      run_block(4, key, pt, aes_ref(4, key, pt), "rand128");
      run_block(6, key, pt, aes_ref(6, key, pt), "rand192");
      run_block(8, key, pt, aes_ref(8, key, pt), "rand256");
    end

    key = {rnd128(), rnd128()};
    ks = expand(4, key);
    for (int i = 0; i < 3; i++) pts[i] = rnd128();
    idx = 0;
    for (int cyc = 0; cyc < 45; cyc++) begin
      @(negedge clk);
      if (b4.outValid) begin
        oc.push_back(cyc);
        outs.push_back(b4.out);
      end
      if (b4.inReady) begin
        if (idx < 3) begin
          drive(4, 1'b1, pts[idx], ks);
          acc.push_back(cyc);
          idx++;
        end else drive(4, 1'b0, '0, ks);
      end
    end
    chk("b2b_accepts", 128'(acc.size()), 128'd3);
    chk("b2b_pulses", 128'(oc.size()), 128'd3);
    for (int i = 0; i < 3; i++)
      if (i < acc.size() && i < oc.size() && i < outs.size()) begin
        chk("b2b_period", 128'(acc[i] - acc[0]), 128'(12 * i));
        chk("b2b_latency", 128'(oc[i] - acc[i]), 128'd11);
        chk("b2b_out", outs[i], aes_ref(4, key, pts[i]));
      end

    ks = expand(4, K4);
    @(negedge clk);
    drive(4, 1'b1, PT, ks);
    @(negedge clk);
    drive(4, 1'b0, rnd128(), ks);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_flags", 128'({b4.outValid, b4.busy, b4.inReady}), 128'b001);
    chk("abort_state", b4.out, 128'h0);
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      pulses += int'(b4.outValid);
    end
    chk("abort_no_valid", 128'(pulses), 128'd0);
    run_block(4, K4, PT, C4, "after_abort");

`ifdef AES_BACKPRESSURE_EN
    b4.outReady = 1'b0;
    @(negedge clk);
    drive(4, 1'b1, PT, ks);
    @(negedge clk);
    drive(4, 1'b0, rnd128(), ks);
    k = 0;
    while (!b4.outValid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("bp_latency", 128'(k), 128'd10);
    chk("bp_out", b4.out, C4);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!(b4.outValid && b4.out === C4 && !b4.inReady)) bad++;
    end
    chk("bp_hold", 128'(bad), 128'd0);
    b4.outReady = 1'b1;
    @(negedge clk);
    chk("bp_release", 128'({b4.outValid, b4.inReady}), 128'b01);
`else
    bad = 0;
    k = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
